cla_subtractor_pipe_32bit: RTL and testbench
============================================

# cla_subtractor_pipe_32bit

Two-stage pipelined subtractor computing a_i − b_i − bin_i. Each stage is one half-width CLA slice; the inter-half borrow is registered between the stages. Valid/ready handshakes on both sides support full throughput and backpressure. It is the subtract/compare counterpart to the team's CLA adders and feeds comparison and ALU-flag logic.

## Interface
- WIDTH, 32, operand width; must be even and ≥ 4; each stage handles WIDTH/2 bits
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  synchronous reset, active-high
- in_valid_i  input  1  operands present
- in_ready_o  output  1  block accepts operands this cycle
- a_i  input  WIDTH  minuend
- b_i  input  WIDTH  subtrahend
- bin_i  input  1  borrow in (1 = subtract one more)
- out_valid_o  output  1  result present
- out_ready_i  input  1  consumer takes result this cycle
- diff_o  output  WIDTH  a − b − bin, modulo 2^WIDTH
- borrow_o  output  1  unsigned borrow out: 1 iff a < b + bin (unsigned)
- ovf_o  output  1  signed overflow
- zero_o  output  1  diff_o == 0
- neg_o  output  1  diff_o[WIDTH-1]
- lt_o  output  1  signed a < b + bin, defined as neg_o ^ ovf_o

## Operation
- Arithmetic: diff = a + ~b + ~bin; the carry into bit 0 is ~bin_i, and borrow = ~carry_out of the top bit. All full WIDTH+1 internal carry, no truncation before flags.
- Stage 1 (s1), loaded on an accepted input:
  - low-half difference
  - low-half carry-out
  - low-half zero flag
  - upper halves of a and ~b
  - a[WIDTH-1] and b[WIDTH-1] for overflow
  - s1_valid
- Stage 2 (s2, output registers), loaded when s1 advances:
  - upper-half difference from the s1 operands and the registered low carry
  - full diff_o
  - borrow_o = ~upper carry-out
  - ovf_o = (a_msb != b_msb) & (diff_msb != a_msb)
  - zero_o = low_zero & (upper half == 0)
  - neg_o
  - lt_o
  - out_valid_o
- Flow control, all combinational from registered state:
  - s2_en = ~out_valid_o | out_ready_i
  - s1_en = ~s1_valid | s2_en
  - in_ready_o = s1_en
- Input accept occurs when in_valid_i & in_ready_o. On s1_en, s1_valid ← accept; s1 data loads only on accept.
- On s2_en, out_valid_o ← s1_valid; s2 data loads only when s1_valid. With no new data, the s2 data registers hold.
- Results leave strictly in acceptance order. No result is dropped or duplicated.
- While out_valid_o & ~out_ready_i, all s2 outputs are held stable.

## Timing
- Reset, synchronous with rst_i high at a rising edge:
  - s1_valid = 0, out_valid_o = 0
  - diff_o = 0, borrow_o = 0, ovf_o = 0, neg_o = 0, lt_o = 0, zero_o = 1 (consistent with diff_o = 0)
  - in_ready_o = 1 from the first cycle after reset
- Reset mid-operation discards both in-flight entries with no output. Inputs presented during the reset cycle are not accepted.
- Latency: an operand accepted at edge k produces out_valid_o high in the cycle after edge k+1 (two edges), given no stall.
- Throughput: one result per cycle while out_ready_i = 1.
- Full condition: s1_valid & out_valid_o & ~out_ready_i forces in_ready_o = 0.
- Simultaneous events:
  - When full and out_ready_i rises, in_ready_o = 1 in that same cycle.
  - A new accept, an s1→s2 move and an output handshake all occur on one edge.
- A consumer may assert out_ready_i with out_valid_o low. This has no effect.

## Test plan
- Basic subtraction: a = 0x00000005, b = 0x00000003, bin = 0 → diff 0x00000002; borrow, ovf, zero, neg and lt all 0; out_valid 2 edges after accept.
- Unsigned borrow: a = 0x00000000, b = 0x00000001 → diff 0xFFFFFFFF, borrow 1, neg 1, ovf 0, lt 1.
- Signed overflow: a = 0x80000000, b = 0x00000001 → diff 0x7FFFFFFF, ovf 1, neg 0, lt 1, borrow 0.
- Cross-half borrow and bin:
  - a = 0x00010000, b = 0x00000001 → 0x0000FFFF.
  - a = b = 0x1234ABCD, bin = 0 → zero 1, borrow 0.
  - a = b = 0x1234ABCD, bin = 1 → 0xFFFFFFFF, borrow 1.
- Backpressure: stream 4 back-to-back operand pairs with out_ready_i held 0 for 5 cycles.
  - Exactly 2 are accepted, then in_ready_o = 0.
  - diff_o stays stable during the stall.
  - After release, all 4 results emerge in order, one per cycle, with none lost or repeated.
- Reset mid-flight: accept 2 operations, assert rst_i for 1 cycle → out_valid_o = 0, in_ready_o = 1, outputs at reset values; the next accepted operation returns the correct result after 2 edges.

Source files
------------

// File: rtl/cla_subtractor_pipe_32bit_if.sv
// Operand/result handshake bundle for the pipelined CLA subtractor.
// The master drives operands and consumer ready; the slave returns results and flags.
interface cla_subtractor_pipe_32bit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             bin_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] diff_o;
  logic             borrow_o;
  logic             ovf_o;
  logic             zero_o;
  logic             neg_o;
  logic             lt_o;

  modport master (
    output in_valid_i, a_i, b_i, bin_i, out_ready_i,
    input  in_ready_o, out_valid_o, diff_o, borrow_o, ovf_o, zero_o, neg_o, lt_o
  );

  modport slave (
    input  in_valid_i, a_i, b_i, bin_i, out_ready_i,
    output in_ready_o, out_valid_o, diff_o, borrow_o, ovf_o, zero_o, neg_o, lt_o
  );
endinterface

// File: rtl/cla_subtractor_pipe_32bit.sv
// Two-stage pipelined subtractor (a - b - bin): low half in stage 1, upper half and flags in stage 2.
// WIDTH must be even and at least 4; each stage is a WIDTH/2-bit prefix-carry slice.
module cla_subtractor_pipe_32bit #(
  parameter int WIDTH = 32
) (
  input logic                       clk_i,
  input logic                       rst_i,
  cla_subtractor_pipe_32bit_if.slave bus
);
  localparam int HALF = WIDTH / 2;

  // Kogge-Stone carry slice; the carry-in is folded into bit 0's generate so the
  // prefix tree yields every carry directly. Returns {carry_out, sum}.
  function automatic logic [HALF:0] cla_slice(input logic [HALF-1:0] x,
                                              input logic [HALF-1:0] y,
                                              input logic            cin);
    logic [HALF-1:0] g;
    logic [HALF-1:0] p;
    logic [HALF-1:0] gg;
    logic [HALF-1:0] pp;
    logic [HALF-1:0] gn;
    logic [HALF-1:0] pn;
    logic [HALF:0]   c;
    g     = x & y;
    p     = x ^ y;
    gg    = g;
    pp    = p;
    gg[0] = g[0] | (p[0] & cin);
    for (int d = 1; d < HALF; d = d * 2) begin
      gn = gg;
      pn = pp;
      for (int i = d; i < HALF; i++) begin
        gn[i] = gg[i] | (pp[i] & gg[i-d]);
        pn[i] = pp[i] & pp[i-d];
      end
      gg = gn;
      pp = pn;
    end
    c = {gg, cin};
    return {c[HALF], p ^ c[HALF-1:0]};
  endfunction

  // Stage 1 state
  logic            s1_valid;
  logic [HALF-1:0] s1_lo_diff;
  logic            s1_lo_carry;
  logic            s1_lo_zero;
  logic [HALF-1:0] s1_a_hi;
  logic [HALF-1:0] s1_nb_hi;
  logic            s1_a_msb;
  logic            s1_b_msb;

  logic s2_en;
  logic s1_en;
  logic accept;

  assign s2_en         = ~bus.out_valid_o | bus.out_ready_i;
  assign s1_en         = ~s1_valid | s2_en;
  assign bus.in_ready_o = s1_en;
  assign accept        = bus.in_valid_i & s1_en;

  // Subtraction as a + ~b + ~bin: the low slice's carry-in is the inverted borrow-in.
  logic [HALF:0] lo_sum;
  logic [HALF:0] hi_sum;
  always_comb begin
    lo_sum = cla_slice(bus.a_i[HALF-1:0], ~bus.b_i[HALF-1:0], ~bus.bin_i);
    hi_sum = cla_slice(s1_a_hi, s1_nb_hi, s1_lo_carry);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= accept;
    end
  end

  // NOTE: stage-1 data registers carry no reset; s1_valid alone qualifies them.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      s1_lo_diff  <= lo_sum[HALF-1:0];
      s1_lo_carry <= lo_sum[HALF];
      s1_lo_zero  <= (lo_sum[HALF-1:0] == '0);
      s1_a_hi     <= bus.a_i[WIDTH-1:HALF];
      s1_nb_hi    <= ~bus.b_i[WIDTH-1:HALF];
      s1_a_msb    <= bus.a_i[WIDTH-1];
      s1_b_msb    <= bus.b_i[WIDTH-1];
    end
  end

  logic diff_msb;
  logic ovf_next;
  assign diff_msb = hi_sum[HALF-1];
  assign ovf_next = (s1_a_msb != s1_b_msb) & (diff_msb != s1_a_msb);

  // Stage 2: output registers; they hold whenever the consumer stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.out_valid_o <= 1'b0;
      bus.diff_o      <= '0;
      bus.borrow_o    <= 1'b0;
      bus.ovf_o       <= 1'b0;
      bus.zero_o      <= 1'b1;
      bus.neg_o       <= 1'b0;
      bus.lt_o        <= 1'b0;
    end else if (s2_en) begin
      bus.out_valid_o <= s1_valid;
      if (s1_valid) begin
        bus.diff_o   <= {hi_sum[HALF-1:0], s1_lo_diff};
        bus.borrow_o <= ~hi_sum[HALF];
        bus.ovf_o    <= ovf_next;
        bus.zero_o   <= s1_lo_zero & (hi_sum[HALF-1:0] == '0);
        bus.neg_o    <= diff_msb;
        bus.lt_o     <= diff_msb ^ ovf_next;
      end
    end
  end
endmodule

// File: tb/tb_cla_subtractor_pipe_32bit.sv
// Scoreboard bench for cla_subtractor_pipe_32bit: directed vectors with hand-computed results,
// a decoupled output monitor, backpressure and mid-flight reset scenarios.
module tb_cla_subtractor_pipe_32bit;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] diff;
    logic        borrow;
    logic        ovf;
    logic        zero;
    logic        neg;
    logic        lt;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cla_subtractor_pipe_32bit_if #(.WIDTH(32)) bus ();

  cla_subtractor_pipe_32bit #(.WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  int   accepted = 0;
  vec_t exp_q[$];
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one operand pair until accepted; the expected result enters the scoreboard on the accept edge.
  task automatic send(input vec_t v);
    int  waited = 0;
    bit  done   = 1'b0;
    while (!done) begin
      @(negedge clk);
      bus.in_valid_i = 1'b1;
      bus.a_i        = v.a;
      bus.b_i        = v.b;
      bus.bin_i      = v.bin;
      #2;
      if (bus.in_ready_o) begin
        @(posedge clk);
        exp_q.push_back(v);
        accepted++;
        done = 1'b1;
        #1 bus.in_valid_i = 1'b0;
      end else begin
        waited++;
        if (waited > 50) begin
          checks++;
          failures++;
          $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", waited);
          bus.in_valid_i = 1'b0;
          done = 1'b1;
        end
      end
    end
  endtask

  // Monitor: samples mid-cycle; a visible valid&ready means the handshake completes at the next edge.
  logic        stall_seen = 1'b0;
  logic [31:0] stall_diff;
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      stall_seen = 1'b0;
    end else begin
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result: got diff %h, required no output", bus.diff_o);
        end else begin
          vec_t e;
          e = exp_q.pop_front();
          check("diff",   bus.diff_o,          e.diff);
          check("borrow", 32'(bus.borrow_o),   32'(e.borrow));
          check("ovf",    32'(bus.ovf_o),      32'(e.ovf));
          check("zero",   32'(bus.zero_o),     32'(e.zero));
          check("neg",    32'(bus.neg_o),      32'(e.neg));
          check("lt",     32'(bus.lt_o),       32'(e.lt));
        end
      end
      if (bus.out_valid_o && !bus.out_ready_i) begin
        if (stall_seen) check("stall_hold_diff", bus.diff_o, stall_diff);
        stall_seen = 1'b1;
        stall_diff = bus.diff_o;
      end else begin
        stall_seen = 1'b0;
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid_o), 32'd0);
    check({tag, "_in_ready"},  32'(bus.in_ready_o),  32'd1);
    check({tag, "_diff"},      bus.diff_o,           32'd0);
    check({tag, "_borrow"},    32'(bus.borrow_o),    32'd0);
    check({tag, "_ovf"},       32'(bus.ovf_o),       32'd0);
    check({tag, "_zero"},      32'(bus.zero_o),      32'd1);
    check({tag, "_neg"},       32'(bus.neg_o),       32'd0);
    check({tag, "_lt"},        32'(bus.lt_o),        32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int base;
    int n;
    //            a             b             bin   diff          brw   ovf   zero  neg   lt
    vecs[0]  = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{32'h00010000, 32'h00000001, 1'b0, 32'h0000FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'h1234ABCD, 32'h1234ABCD, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{32'h1234ABCD, 32'h1234ABCD, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{32'h00000010, 32'h00000001, 1'b0, 32'h0000000F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'h00000100, 32'h00000100, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{32'h0000FFFF, 32'h00010000, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 32'h4B4B4B4B, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    bus.in_valid_i  = 1'b0;
    bus.a_i         = '0;
    bus.b_i         = '0;
    bus.bin_i       = 1'b0;
    bus.out_ready_i = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #2;
    check_reset_state("reset");

    // Basic subtraction with explicit two-edge latency
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    send(vecs[0]);
    check("latency_edge1_valid", 32'(bus.out_valid_o), 32'd0);
    @(posedge clk);
    #1;
    check("latency_edge2_valid", 32'(bus.out_valid_o), 32'd1);
    check("latency_edge2_diff",  bus.diff_o,           32'h00000002);

    for (int i = 1; i < 8; i++) send(vecs[i]);
    drain();

    // Backpressure: four back-to-back pairs against a five-cycle stall
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    base = accepted;
    fork
      begin
        for (int i = 8; i < 12; i++) send(vecs[i]);
      end
    join_none
    repeat (5) @(negedge clk);
    #2;
    check("bp_accepted_in_stall", 32'(accepted - base), 32'd2);
    check("bp_in_ready_full",     32'(bus.in_ready_o),  32'd0);
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("bp_release_valid", 32'(bus.out_valid_o), 32'd1);
      @(negedge clk);
    end
    n = 0;
    while ((accepted - base) < 4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_total_accepted", 32'(accepted - base), 32'd4);
    drain();

    // Reset mid-flight with two operations in the pipe and inputs offered during reset
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    send(vecs[2]);
    send(vecs[3]);
    @(negedge clk);
    rst            = 1'b1;
    exp_q.delete();
    bus.in_valid_i = 1'b1;
    bus.a_i        = 32'h00000009;
    bus.b_i        = 32'h00000004;
    bus.bin_i      = 1'b0;
    @(negedge clk);
    rst            = 1'b0;
    bus.in_valid_i = 1'b0;
    #2;
    check_reset_state("midrst");
    @(negedge clk);
    #2;
    check("midrst_no_ghost_valid", 32'(bus.out_valid_o), 32'd0);
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    send(vecs[6]);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
